morse_decoder: RTL and testbench



---
 rtl/morse_decoder_if.sv | 20 ++
 rtl/morse_decoder.sv | 167 ++++++++++++++++
 tb/tb_morse_decoder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_decoder_if.sv
// Keyed-input and decoded-character signal bundle for morse_decoder.
// master: keyed-signal source / output consumer; slave: the decoder.
interface morse_decoder_if;
    logic       key_in;
    logic       char_valid;
    logic [7:0] char_code;
    logic       char_known;
    logic       word_gap;
    logic       busy;

    modport master (
        output key_in,
        input  char_valid, char_code, char_known, word_gap, busy
    );

    modport slave (
        input  key_in,
        output char_valid, char_code, char_known, word_gap, busy
    );
endinterface

// File: rtl/morse_decoder.sv
// On-off keyed Morse receiver: run-length timing into dot/dash, character and word gaps, ASCII out.
// Define MORSE_PUNCT_EN to add . , ? / = to the decode table.
module morse_decoder #(
    parameter int unsigned UNIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    morse_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] DASH_T = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_T = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_T = CNT_W'(5 * UNIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_run_len, w_run_len_nxt, w_run_inc;
    logic [5:0]       r_pattern, w_pattern_nxt, w_mask;
    logic [2:0]       r_elem_cnt, w_elem_cnt_nxt;
    logic             r_char_valid, w_char_valid_nxt;
    logic [7:0]       r_char_code, w_char_code_nxt;
    logic             r_char_known, w_char_known_nxt;
    logic             r_word_gap, w_word_gap_nxt;
    logic [8:0]       w_dec;

    assign w_run_inc = (r_run_len == '1) ? r_run_len : r_run_len + CNT_W'(1);

    // Mask off stale bits above elem_cnt; a count of 7 keeps all six bits and decodes to '?'.
    assign w_mask = 6'((7'd1 << r_elem_cnt) - 7'd1);

    always_comb begin
        w_dec = {1'b0, 8'h3F};
        case ({r_elem_cnt, r_pattern & w_mask})
            {3'd2, 6'b000001}: w_dec = {1'b1, "A"};
            {3'd4, 6'b001000}: w_dec = {1'b1, "B"};
            {3'd4, 6'b001010}: w_dec = {1'b1, "C"};
            {3'd3, 6'b000100}: w_dec = {1'b1, "D"};
            {3'd1, 6'b000000}: w_dec = {1'b1, "E"};
            {3'd4, 6'b000010}: w_dec = {1'b1, "F"};
            {3'd3, 6'b000110}: w_dec = {1'b1, "G"};
            {3'd4, 6'b000000}: w_dec = {1'b1, "H"};
            {3'd2, 6'b000000}: w_dec = {1'b1, "I"};
            {3'd4, 6'b000111}: w_dec = {1'b1, "J"};
            {3'd3, 6'b000101}: w_dec = {1'b1, "K"};
            {3'd4, 6'b000100}: w_dec = {1'b1, "L"};
            {3'd2, 6'b000011}: w_dec = {1'b1, "M"};
            {3'd2, 6'b000010}: w_dec = {1'b1, "N"};
            {3'd3, 6'b000111}: w_dec = {1'b1, "O"};
            {3'd4, 6'b000110}: w_dec = {1'b1, "P"};
            {3'd4, 6'b001101}: w_dec = {1'b1, "Q"};
            {3'd3, 6'b000010}: w_dec = {1'b1, "R"};
            {3'd3, 6'b000000}: w_dec = {1'b1, "S"};
            {3'd1, 6'b000001}: w_dec = {1'b1, "T"};
            {3'd3, 6'b000001}: w_dec = {1'b1, "U"};
            {3'd4, 6'b000001}: w_dec = {1'b1, "V"};
            {3'd3, 6'b000011}: w_dec = {1'b1, "W"};
            {3'd4, 6'b001001}: w_dec = {1'b1, "X"};
            {3'd4, 6'b001011}: w_dec = {1'b1, "Y"};
            {3'd4, 6'b001100}: w_dec = {1'b1, "Z"};
            {3'd5, 6'b011111}: w_dec = {1'b1, "0"};
            {3'd5, 6'b001111}: w_dec = {1'b1, "1"};
            {3'd5, 6'b000111}: w_dec = {1'b1, "2"};
            {3'd5, 6'b000011}: w_dec = {1'b1, "3"};
            {3'd5, 6'b000001}: w_dec = {1'b1, "4"};
            {3'd5, 6'b000000}: w_dec = {1'b1, "5"};
            {3'd5, 6'b010000}: w_dec = {1'b1, "6"};
            {3'd5, 6'b011000}: w_dec = {1'b1, "7"};
            {3'd5, 6'b011100}: w_dec = {1'b1, "8"};
            {3'd5, 6'b011110}: w_dec = {1'b1, "9"};
`ifdef MORSE_PUNCT_EN
            {3'd6, 6'b010101}: w_dec = {1'b1, "."};
            {3'd6, 6'b110011}: w_dec = {1'b1, ","};
            {3'd6, 6'b001100}: w_dec = {1'b1, "?"};
            {3'd5, 6'b010010}: w_dec = {1'b1, "/"};
            {3'd5, 6'b010001}: w_dec = {1'b1, "="};
`else
            {3'd6, 6'b010101}, {3'd6, 6'b110011}, {3'd6, 6'b001100},
            {3'd5, 6'b010010}, {3'd5, 6'b010001}: w_dec = {1'b0, 8'h3F};
`endif
            default: w_dec = {1'b0, 8'h3F};
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_run_len_nxt    = r_run_len;
        w_pattern_nxt    = r_pattern;
        w_elem_cnt_nxt   = r_elem_cnt;
        w_char_valid_nxt = 1'b0;
        w_char_code_nxt  = r_char_code;
        w_char_known_nxt = r_char_known;
        w_word_gap_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.key_in) begin
                    w_state_nxt   = S_MARK;
                    w_run_len_nxt = CNT_W'(1);
                end
            end
            S_MARK: begin
                if (bus.key_in) begin
                    w_run_len_nxt = w_run_inc;
                end else begin
                    w_pattern_nxt  = {r_pattern[4:0], (r_run_len >= DASH_T)};
                    w_elem_cnt_nxt = (r_elem_cnt == 3'd7) ? r_elem_cnt : r_elem_cnt + 3'd1;
                    w_state_nxt    = S_SPACE;
                    w_run_len_nxt  = CNT_W'(1);
                end
            end
            S_SPACE: begin
                if (bus.key_in) begin
                    w_state_nxt   = S_MARK;
                    w_run_len_nxt = CNT_W'(1);
                end else begin
                    w_run_len_nxt = w_run_inc;
                    if (w_run_inc == CHAR_T) begin
                        w_char_valid_nxt = 1'b1;
                        w_char_known_nxt = w_dec[8];
                        w_char_code_nxt  = w_dec[7:0];
                        w_pattern_nxt    = '0;
                        w_elem_cnt_nxt   = '0;
                    end
                    if (w_run_inc == WORD_T) begin
                        w_word_gap_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                        w_run_len_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_run_len_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_run_len    <= '0;
            r_pattern    <= '0;
            r_elem_cnt   <= '0;
            r_char_valid <= 1'b0;
            r_char_code  <= '0;
            r_char_known <= 1'b0;
            r_word_gap   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_run_len    <= w_run_len_nxt;
            r_pattern    <= w_pattern_nxt;
            r_elem_cnt   <= w_elem_cnt_nxt;
            r_char_valid <= w_char_valid_nxt;
            r_char_code  <= w_char_code_nxt;
            r_char_known <= w_char_known_nxt;
            r_word_gap   <= w_word_gap_nxt;
        end
    end

    assign bus.char_valid = r_char_valid;
    assign bus.char_code  = r_char_code;
    assign bus.char_known = r_char_known;
    assign bus.word_gap   = r_word_gap;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: keyed streams are built from dot/dash text, expectations come from
// a run-length / string-lookup model of the Morse timing rules.
module tb_morse_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morse_decoder_if if1 ();
    morse_decoder_if if4 ();

    morse_decoder #(.UNIT_CYCLES(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    morse_decoder #(.UNIT_CYCLES(4), .CNT_W(16)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic sel4 = 1'b0;

    logic       o_cv, o_known, o_wg, o_busy;
    logic [7:0] o_code;

    logic       q_key[$];
    logic       e_cv[$], e_known[$], e_wg[$], e_busy[$];
    logic [7:0] e_code[$];

    string mtab[$];
    byte   atab[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic add(input byte c, input string m);
        atab.push_back(c);
        mtab.push_back(m);
    endtask

    task automatic lookup(input string m, output logic [7:0] code, output logic known);
        code  = 8'h3F;
        known = 1'b0;
        foreach (mtab[i]) if (mtab[i] == m) begin
            code  = atab[i];
            known = 1'b1;
        end
    endtask

    task automatic observe();
        if (sel4) begin
            o_cv = if4.char_valid; o_code = if4.char_code; o_known = if4.char_known;
            o_wg = if4.word_gap;   o_busy = if4.busy;
        end else begin
            o_cv = if1.char_valid; o_code = if1.char_code; o_known = if1.char_known;
            o_wg = if1.word_gap;   o_busy = if1.busy;
        end
    endtask

    task automatic step(input logic k);
        if (sel4) if4.key_in = k; else if1.key_in = k;
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic do_reset(input logic k);
        if (sel4) if4.key_in = k; else if1.key_in = k;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        observe();
        chk("rst_char_valid", o_cv, 0);
        chk("rst_char_code", o_code, 0);
        chk("rst_char_known", o_known, 0);
        chk("rst_word_gap", o_wg, 0);
        chk("rst_busy", o_busy, 0);
    endtask

    task automatic runs(input logic v, input int n);
        repeat (n) q_key.push_back(v);
    endtask

    task automatic push_char(input string m, input int dot, input int dash, input int intra, input int trail);
        for (int j = 0; j < m.len(); j++) begin
            runs(1'b1, (m[j] == "-") ? dash : dot);
            if (j < m.len() - 1) runs(1'b0, intra);
        end
        runs(1'b0, trail);
    endtask

    // Expected outputs from run lengths: marks become '.'/'-', a long enough silence ends the
    // character (table lookup) or the word; silence outside a word is ignored.
    task automatic build_expect(input int unit);
        int dash_t = 2 * unit;
        int char_t = 2 * unit;
        int word_t = 5 * unit;
        string pend = "";
        logic idle = 1'b1;
        logic [7:0] hc = 8'h00;
        logic hk = 1'b0;
        int i = 0;
        int n = q_key.size();
        while (i < n) begin
            int j = i;
            int len;
            while (j < n && q_key[j] == q_key[i]) j++;
            len = j - i;
            if (q_key[i]) begin
                idle = 1'b0;
                for (int t = i; t < j; t++) begin
                    e_cv.push_back(1'b0); e_code.push_back(hc); e_known.push_back(hk);
                    e_wg.push_back(1'b0); e_busy.push_back(1'b1);
                end
                if (j < n) begin
                    if (len >= dash_t) pend = {pend, "-"}; else pend = {pend, "."};
                end
            end else begin
                for (int z = 1; z <= len; z++) begin
                    logic cv = 1'b0;
                    logic wg = 1'b0;
                    if (!idle && z == char_t) begin
                        lookup(pend, hc, hk);
                        pend = "";
                        cv = 1'b1;
                    end
                    if (!idle && z == word_t) begin
                        wg = 1'b1;
                        idle = 1'b1;
                    end
                    e_cv.push_back(cv); e_code.push_back(hc); e_known.push_back(hk);
                    e_wg.push_back(wg); e_busy.push_back(!idle);
                end
            end
            i = j;
        end
    endtask

    task automatic run_check(input int unit, input bit with_reset);
        if (with_reset) do_reset(1'b0);
        build_expect(unit);
        foreach (q_key[t]) begin
            step(q_key[t]);
            chk("char_valid", o_cv, e_cv[t]);
            chk("char_code", o_code, e_code[t]);
            chk("char_known", o_known, e_known[t]);
            chk("word_gap", o_wg, e_wg[t]);
            chk("busy", o_busy, e_busy[t]);
        end
        q_key.delete(); e_cv.delete(); e_code.delete(); e_known.delete();
        e_wg.delete(); e_busy.delete();
    endtask

    task automatic check_last(input logic [7:0] code, input logic known);
        chk("last_code", o_code, code);
        chk("last_known", o_known, known);
    endtask

    task automatic random_text(input int unit, input int nchars);
        for (int c = 0; c < nchars; c++) begin
            string m = "";
            int trail;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 7)) begin
                    if ($urandom_range(0, 1) == 1) m = {m, "-"}; else m = {m, "."};
                end
            end else begin
                m = mtab[$urandom_range(0, mtab.size() - 1)];
            end
            if (c == nchars - 1 || $urandom_range(0, 2) == 0)
                trail = $urandom_range(5 * unit, 5 * unit + 3);
            else
                trail = $urandom_range(2 * unit, 5 * unit - 1);
            push_char(m, $urandom_range(1, 2 * unit - 1), $urandom_range(2 * unit, 3 * unit),
                      $urandom_range(1, 2 * unit - 1), trail);
        end
    endtask

    initial begin
        string cs[6];
        rst = 1'b1;
        if1.key_in = 1'b0;
        if4.key_in = 1'b0;

        add("A", ".-");    add("B", "-...");  add("C", "-.-.");  add("D", "-..");
        add("E", ".");     add("F", "..-.");  add("G", "--.");   add("H", "....");
        add("I", "..");    add("J", ".---");  add("K", "-.-");   add("L", ".-..");
        add("M", "--");    add("N", "-.");    add("O", "---");   add("P", ".--.");
        add("Q", "--.-");  add("R", ".-.");   add("S", "...");   add("T", "-");
        add("U", "..-");   add("V", "...-");  add("W", ".--");   add("X", "-..-");
        add("Y", "-.--");  add("Z", "--..");
        add("0", "-----"); add("1", ".----"); add("2", "..---"); add("3", "...--");
        add("4", "....-"); add("5", "....."); add("6", "-...."); add("7", "--...");
        add("8", "---.."); add("9", "----.");
`ifdef MORSE_PUNCT_EN
        add(".", ".-.-.-"); add(",", "--..--"); add("?", "..--..");
        add("/", "-..-.");  add("=", "-...-");
`endif

        // K at one cycle per unit: 111 0 1 0 111 then 000
        sel4 = 1'b0;
        push_char("-.-", 1, 3, 1, 3);
        run_check(1, 1'b1);
        check_last(8'h4B, 1'b1);

        // Callsign K E 8 F C U, two passes, 7-zero trailer
        cs[0] = "-.-"; cs[1] = "."; cs[2] = "---.."; cs[3] = "..-."; cs[4] = "-.-."; cs[5] = "..-";
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 6; k++) push_char(cs[k], 1, 3, 1, (k == 5) ? 7 : 3);
        run_check(1, 1'b1);
        check_last(8'h55, 1'b1);
        chk("busy_after_word", o_busy, 0);

        // Dash threshold at four cycles per unit
        sel4 = 1'b1;
        runs(1'b1, 8); runs(1'b0, 4); runs(1'b1, 7); runs(1'b0, 8);
        run_check(4, 1'b1);
        check_last(8'h4E, 1'b1);
        runs(1'b1, 7); runs(1'b0, 4); runs(1'b1, 7); runs(1'b0, 8);
        run_check(4, 1'b1);
        check_last(8'h49, 1'b1);

        // Seven dots: element count saturates
        sel4 = 1'b0;
        push_char(".......", 1, 3, 1, 2);
        run_check(1, 1'b1);
        check_last(8'h3F, 1'b0);

        // Reset during the second mark of -.- discards it
        do_reset(1'b0);
        step(1'b1); step(1'b1); step(1'b1); step(1'b0); step(1'b1);
        chk("pre_rst_no_strobe", o_cv, 0);
        do_reset(1'b1);
        push_char(".", 1, 3, 1, 2);
        run_check(1, 1'b0);
        check_last(8'h45, 1'b1);

        // Slash pattern: known only with punctuation enabled
        push_char("-..-.", 1, 3, 1, 2);
        run_check(1, 1'b1);
`ifdef MORSE_PUNCT_EN
        check_last(8'h2F, 1'b1);
`else
        check_last(8'h3F, 1'b0);
`endif

        // Full table sweep, then randomized text at both unit lengths
        foreach (mtab[k]) push_char(mtab[k], 1, 3, 1, (k == mtab.size() - 1) ? 7 : 3);
        run_check(1, 1'b1);
        random_text(1, 40);
        run_check(1, 1'b1);
        sel4 = 1'b1;
        random_text(4, 30);
        run_check(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
